// File: rtl/booth_mul_seq_if.sv
// Request/response bundle for the sequential Booth multiplier.
// The requester drives start/tc/x/y and the multiplier returns busy/done/z.
interface booth_mul_seq_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               tc;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] z;

  modport master (
    output start, tc, x, y,
    input  busy, done, z
  );

  modport slave (
    input  start, tc, x, y,
    output busy, done, z
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, WIDTH+1 steps per product,
// signed or unsigned operands selected per request.
module booth_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  booth_mul_seq_if.slave  bus
);
  localparam int EW = WIDTH + 1;
  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [AW-1:0]      a_r, a_s;
  logic [EW-1:0]      q_r, q_s;
  logic               q1_r, q1_s;
  logic [EW-1:0]      m_r, m_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic [2*WIDTH-1:0] z_r, z_s;
  logic [AW-1:0]      m_wide_s;
  logic [AW-1:0]      sum_s;
  logic [AW+EW-1:0]   shifted_s;

  // One extra bit lets unsigned operands ride through the signed Booth recoding.
  function automatic logic [EW-1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
    extend = {sgn & v[WIDTH-1], v};
  endfunction

  // Booth add/subtract followed by the arithmetic right shift of {A, Q, q_1}.
  always_comb begin
    m_wide_s = {m_r[EW-1], m_r};
    case ({q_r[0], q1_r})
      2'b10:   sum_s = a_r - m_wide_s;
      2'b01:   sum_s = a_r + m_wide_s;
      default: sum_s = a_r;
    endcase
    shifted_s = {sum_s[AW-1], sum_s, q_r[EW-1:1]};
  end

  // Next-state and datapath update for the IDLE/RUN controller.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    q_s     = q_r;
    q1_s    = q1_r;
    m_s     = m_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    z_s     = z_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          a_s     = {AW{1'b0}};
          q_s     = extend(bus.x, bus.tc);
          q1_s    = 1'b0;
          m_s     = extend(bus.y, bus.tc);
          cnt_s   = {CW{1'b0}};
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        a_s   = shifted_s[AW+EW-1:EW];
        q_s   = shifted_s[EW-1:0];
        q1_s  = q_r[0];
        cnt_s = cnt_r + CW'(1);
        // Low 2*WIDTH bits of the shifted pair are exact for both operand modes.
        if (cnt_r == CW'(WIDTH)) begin
          z_s     = shifted_s[2*WIDTH-1:0];
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == RUN);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      a_r     <= {AW{1'b0}};
      q_r     <= {EW{1'b0}};
      q1_r    <= 1'b0;
      m_r     <= {EW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      z_r     <= {(2*WIDTH){1'b0}};
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      q_r     <= q_s;
      q1_r    <= q1_s;
      m_r     <= m_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      z_r     <= z_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.z    = z_r;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq: an 8-bit instance for the scenario tests and a
// 4-bit instance swept exhaustively in both operand modes.
module tb_booth_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  booth_mul_seq_if #(.WIDTH(8)) i8 ();
  booth_mul_seq_if #(.WIDTH(4)) i4 ();

  booth_mul_seq #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(i8.slave));
  booth_mul_seq #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(i4.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic t);
    i8.start = 1'b1;
    i8.x     = a;
    i8.y     = b;
    i8.tc    = t;
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic t);
    i4.start = 1'b1;
    i4.x     = a;
    i4.y     = b;
    i4.tc    = t;
  endtask

  // Called at the negedge where start was driven; returns at the negedge showing done.
  task automatic wait_done8(input string tag, input logic [15:0] exp);
    int n;
    int bc;
    n  = 1;
    bc = 0;
    @(negedge clk);
    i8.start = 1'b0;
    while (i8.done !== 1'b1 && n < 100) begin
      if (i8.busy === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
    check({tag, ".lat"}, n - 1, 32'd9);
    check({tag, ".busy_cycles"}, bc, 32'd9);
    check({tag, ".busy_at_done"}, {31'd0, i8.busy}, 32'd0);
    check({tag, ".z"}, {16'd0, i8.z}, {16'd0, exp});
  endtask

  task automatic wait_done4(input string tag, input logic [7:0] exp);
    int n;
    n = 1;
    @(negedge clk);
    i4.start = 1'b0;
    while (i4.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".lat"}, n - 1, 32'd5);
    check({tag, ".z"}, {24'd0, i4.z}, {24'd0, exp});
  endtask

  initial begin
    int n;
    int dc;
    int sa;
    int sb;
    logic [7:0] e4;

    i8.start = 1'b0; i8.tc = 1'b0; i8.x = 8'h00; i8.y = 8'h00;
    i4.start = 1'b0; i4.tc = 1'b0; i4.x = 4'h0; i4.y = 4'h0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst.busy", {31'd0, i8.busy}, 32'd0);
    check("rst.done", {31'd0, i8.done}, 32'd0);
    check("rst.z", {16'd0, i8.z}, 32'd0);
    check("rst.z4", {24'd0, i4.z}, 32'd0);
    rst = 1'b1;

    // -7 * 5 signed
    @(negedge clk); drive8(8'hF9, 8'h05, 1'b1);
    wait_done8("neg7x5", 16'hFFDD);
    @(negedge clk);
    check("neg7x5.pulse", {31'd0, i8.done}, 32'd0);
    check("neg7x5.zhold", {16'd0, i8.z}, 32'h0000FFDD);

    // Corner operands
    @(negedge clk); drive8(8'h80, 8'h80, 1'b1);
    wait_done8("min_sq", 16'h4000);
    @(negedge clk); drive8(8'hFF, 8'hFF, 1'b0);
    wait_done8("umax_sq", 16'hFE01);
    @(negedge clk); drive8(8'h80, 8'h02, 1'b0);
    wait_done8("u80x2", 16'h0100);

    // Start pulses while busy must be ignored
    @(negedge clk); drive8(8'h03, 8'h04, 1'b1);
    @(negedge clk);
    n = 1;
    while (i8.done !== 1'b1 && n < 100) begin
      if (n <= 4) begin
        i8.start = 1'b1; i8.x = 8'h09; i8.y = 8'h09; i8.tc = ~i8.tc;
      end else begin
        i8.start = 1'b0;
      end
      if (n == 2) check("ign.zstable", {16'd0, i8.z}, 32'h00000100);
      @(negedge clk);
      n++;
    end
    check("ign.lat", n - 1, 32'd9);
    check("ign.z", {16'd0, i8.z}, 32'd12);
    dc = 0;
    repeat (14) begin
      @(negedge clk);
      if (i8.done === 1'b1) dc++;
    end
    check("ign.no_second_done", dc, 32'd0);

    // Reset mid-operation
    @(negedge clk); drive8(8'h0A, 8'h0A, 1'b0);
    @(negedge clk); i8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort.z", {16'd0, i8.z}, 32'd0);
    check("abort.done", {31'd0, i8.done}, 32'd0);
    check("abort.busy", {31'd0, i8.busy}, 32'd0);
    repeat (2) @(negedge clk);
    check("abort.done_hold", {31'd0, i8.done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort.idle_busy", {31'd0, i8.busy}, 32'd0);
    check("abort.idle_z", {16'd0, i8.z}, 32'd0);
    drive8(8'hFF, 8'hFF, 1'b1);
    wait_done8("after_rst", 16'h0001);

    // Back-to-back: second start issued in the done cycle
    @(negedge clk); drive8(8'h02, 8'h03, 1'b1);
    wait_done8("b2b.first", 16'h0006);
    drive8(8'h06, 8'hFD, 1'b1);
    wait_done8("b2b.second", 16'hFFEE);

    // 4-bit instance
    @(negedge clk); drive4(4'h7, 4'h8, 1'b1);
    wait_done4("w4.7xm8", 8'hC8);
    for (int t = 0; t < 2; t++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          if (t == 1) begin
            sa = (a >= 8) ? a - 16 : a;
            sb = (b >= 8) ? b - 16 : b;
          end else begin
            sa = a;
            sb = b;
          end
          e4 = 8'(sa * sb);
          @(negedge clk); drive4(4'(a), 4'(b), t[0]);
          wait_done4($sformatf("w4.t%0d.%0dx%0d", t, a, b), e4);
        end
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
